// File: rtl/reg_file_sb.sv
// Multi-port register file with write-to-read bypass, a pending-write
// scoreboard and a sequential clear engine. x0 is hardwired to zero.
module reg_file_sb #(
    parameter int unsigned NUM_REG        = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned NUM_RD_PORTS   = 2,
    parameter bit          BYPASS         = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0]      rd_data,
    output logic [NUM_RD_PORTS-1:0]                rd_busy,
    input  logic                                   wr_en,
    input  logic [REG_ADDR_WIDTH-1:0]              wr_addr,
    input  logic [REG_WIDTH-1:0]                   wr_data,
    input  logic                                   issue_en,
    input  logic [REG_ADDR_WIDTH-1:0]              issue_addr,
    input  logic                                   clear_req,
    output logic                                   clear_busy
);

    localparam int unsigned AW = REG_ADDR_WIDTH;
    localparam int unsigned W  = REG_WIDTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REG - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [W-1:0]         mem_q [NUM_REG];
    logic [W-1:0]         mem_d [NUM_REG];
    logic [NUM_REG-1:0]   busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= '0;
            for (int unsigned i = 0; i < NUM_REG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (wr_en && (wr_addr != '0)) begin
                    mem_d[wr_addr]  = wr_data;
                    busy_d[wr_addr] = 1'b0;
                end
                // Issue is applied after the write so a new producer wins.
                if (issue_en && (issue_addr != '0)) begin
                    busy_d[issue_addr] = 1'b1;
                end
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = AW'(1);
                end
            end
            CLEAR: begin
                mem_d[idx_q]  = '0;
                busy_d[idx_q] = 1'b0;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clear_busy = (state_q == CLEAR);

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] a;
        logic          wr_hit;

        assign a      = rd_addr[p*AW +: AW];
        assign wr_hit = BYPASS && wr_en && (wr_addr == a);

        assign rd_data[p*W +: W] = (a == '0)                      ? '0 :
                                   (wr_hit && state_q == IDLE)    ? wr_data :
                                                                    mem_q[a];
        assign rd_busy[p] = (state_q == CLEAR) |
                            ((a != '0) & busy_q[a] & ~wr_hit);
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a BYPASS=1 and a BYPASS=0 instance share
// all inputs so their array state is identical and only forwarding differs.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        clear_req;

    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic        clear_busy_b, clear_busy_n;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    always #5 clk = ~clk;

    reg_file_sb #(.NUM_REG(32), .REG_ADDR_WIDTH(5), .REG_WIDTH(32),
                  .NUM_RD_PORTS(2), .BYPASS(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .clear_req(clear_req), .clear_busy(clear_busy_b)
    );

    reg_file_sb #(.NUM_REG(32), .REG_ADDR_WIDTH(5), .REG_WIDTH(32),
                  .NUM_RD_PORTS(2), .BYPASS(1'b0)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .clear_req(clear_req), .clear_busy(clear_busy_n)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
        clear_req  = 1'b0;

        // Reset state on every address and both ports
        #12;
        check("rst_clear_busy", {31'd0, clear_busy_b}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            #1;
            check("rst_rd0", rd_data_b[31:0], 32'd0);
            check("rst_rd1", rd_data_b[63:32], 32'd0);
            check("rst_busy", {30'd0, rd_busy_b}, 32'd0);
        end
        tick();
        rst_n = 1'b1;
        tick();

        // Plain write then read next cycle on port 1
        write_reg(5'd5, 32'hDEADBEEF);
        rd_addr = {5'd5, 5'd0};
        #1;
        check("wr_x5_b", rd_data_b[63:32], 32'hDEADBEEF);
        check("wr_x5_n", rd_data_n[63:32], 32'hDEADBEEF);

        // Same-cycle bypass vs array-only read
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
        rd_addr = {5'd0, 5'd7};
        #1;
        check("byp_x7_b", rd_data_b[31:0], 32'h1234);
        check("byp_x7_n", rd_data_n[31:0], 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        check("x7_next_n", rd_data_n[31:0], 32'h1234);

        // x0 is never written and never busy
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #1;
        check("x0_rd_same", rd_data_b[31:0], 32'd0);
        check("x0_busy_same", {31'd0, rd_busy_b[0]}, 32'd0);
        tick();
        wr_en = 1'b0; issue_en = 1'b0;
        #1;
        check("x0_rd_after", rd_data_b[31:0], 32'd0);
        check("x0_busy_after", {31'd0, rd_busy_b[0]}, 32'd0);

        // Scoreboard: issue x3, then resolve it with a write
        issue_en = 1'b1; issue_addr = 5'd3;
        rd_addr = {5'd0, 5'd3};
        #1;
        check("x3_busy_issue_cyc", {31'd0, rd_busy_b[0]}, 32'd0);
        tick();
        issue_en = 1'b0;
        #1;
        check("x3_busy_b", {31'd0, rd_busy_b[0]}, 32'd1);
        check("x3_busy_n", {31'd0, rd_busy_n[0]}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd9;
        #1;
        check("x3_wrcyc_busy_b", {31'd0, rd_busy_b[0]}, 32'd0);
        check("x3_wrcyc_data_b", rd_data_b[31:0], 32'd9);
        check("x3_wrcyc_busy_n", {31'd0, rd_busy_n[0]}, 32'd1);
        check("x3_wrcyc_data_n", rd_data_n[31:0], 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        check("x3_after_busy_n", {31'd0, rd_busy_n[0]}, 32'd0);
        check("x3_after_data_n", rd_data_n[31:0], 32'd9);

        // Simultaneous issue and write: data lands, busy ends set
        issue_en = 1'b1; issue_addr = 5'd4;
        write_reg(5'd4, 32'h44);
        issue_en = 1'b0;
        rd_addr = {5'd4, 5'd0};
        #1;
        check("x4_busy", {31'd0, rd_busy_b[1]}, 32'd1);
        check("x4_data", rd_data_b[63:32], 32'h44);

        // Fill x1..x31, then clear with interference during the sequence
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'h100 + 32'(i));
        end
        rd_addr = {5'd31, 5'd1};
        #1;
        check("fill_x1", rd_data_b[31:0], 32'h101);
        check("fill_x31", rd_data_b[63:32], 32'h11F);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        while (clear_busy_b && cnt < 40) begin
            cnt++;
            case (cnt)
                5: begin wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hBAD; end
                6: begin wr_en = 1'b0; clear_req = 1'b1; end
                7: begin clear_req = 1'b0; issue_en = 1'b1; issue_addr = 5'd6; end
                8: issue_en = 1'b0;
                10: rd_addr = {5'd20, 5'd9};
                default: ;
            endcase
            #1;
            if (cnt == 1) begin
                check("clr_busy_all_b", {30'd0, rd_busy_b}, 32'd3);
                check("clr_busy_all_n", {30'd0, rd_busy_n}, 32'd3);
            end
            if (cnt == 10) begin
                check("clr_x9_done", rd_data_b[31:0], 32'd0);
                check("clr_x20_pending", rd_data_b[63:32], 32'h114);
            end
            tick();
        end
        check("clr_cycles", 32'(cnt), 32'd31);
        check("clr_busy_done", {31'd0, clear_busy_b}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            rd_addr = {5'd0, 5'(i)};
            #1;
            check("post_clr_data", rd_data_b[31:0], 32'd0);
            check("post_clr_busy", {31'd0, rd_busy_b[0]}, 32'd0);
        end
        tick();
        check("clr_no_restart", {31'd0, clear_busy_b}, 32'd0);

        // Reset in the middle of a clear
        write_reg(5'd25, 32'h55);
        issue_en = 1'b1; issue_addr = 5'd20;
        tick();
        issue_en = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 1;
        while (cnt < 10) begin
            tick();
            cnt++;
        end
        rd_addr = {5'd20, 5'd25};
        #1;
        check("pre_rst_x25", rd_data_b[31:0], 32'h55);
        check("pre_rst_clr", {31'd0, clear_busy_b}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_clr", {31'd0, clear_busy_b}, 32'd0);
        check("mid_rst_x25", rd_data_b[31:0], 32'd0);
        check("mid_rst_busy", {30'd0, rd_busy_b}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("no_resume", {31'd0, clear_busy_b}, 32'd0);
        write_reg(5'd11, 32'hA5A5);
        rd_addr = {5'd11, 5'd0};
        #1;
        check("post_rst_wr_b", rd_data_b[63:32], 32'hA5A5);
        check("post_rst_wr_n", rd_data_n[63:32], 32'hA5A5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
